// File: rtl/l15_buf_pkg.sv
// Shared types and widths for the L1.5 request buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package l15_buf_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  localparam int unsigned OUTST_W = 8;
  localparam int unsigned STATS_W = 32;

  // Saturating increment for the stall statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/l15_req_fifo.sv
// Register FIFO of ReqWidth x Depth holding requests waiting for the L1.5.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: exposes full/empty; the owner must not push when full nor pop when empty.
module l15_req_fifo #(
  parameter int unsigned ReqWidth = 128,
  parameter int unsigned Depth    = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      push,
  input  logic [ReqWidth-1:0]       push_dat,
  input  logic                      pop,
  output logic [ReqWidth-1:0]       head_dat,
  output logic [ReqWidth-1:0]       next_dat,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(Depth):0]    cnt
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned CW = AW + 1;

  logic [ReqWidth-1:0] mem [Depth];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       rd_nxt;

  assign rd_nxt   = rd_ptr + 1'b1;
  assign head_dat = mem[rd_ptr];
  // Entry behind the head, used for back-to-back presentation after a pop.
  assign next_dat = mem[rd_nxt];
  assign full     = (cnt == CW'(Depth));
  assign empty    = (cnt == '0);

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_nxt;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/l15_req_buffer.sv
// Buffers core L1.5 requests and presents them to the L1.5 under an outstanding-request credit limit.
// Latency: core ack in cycle t presents on l15_val_o in t+1 when empty and credit is available.
// Backpressure: core_ack_o drops while the FIFO is full; presentation pauses at MaxOutstanding.
// Optional: define L15_REQ_BUF_STATS_EN to add saturating stall counters.
module l15_req_buffer
  import l15_buf_pkg::*;
#(
  parameter int unsigned ReqWidth       = 128,
  parameter int unsigned Depth          = 4,
  parameter int unsigned MaxOutstanding = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                core_val_i,
  input  logic [ReqWidth-1:0] core_req_i,
  output logic                core_ack_o,
  output logic                l15_val_o,
  output logic [ReqWidth-1:0] l15_req_o,
  input  logic                l15_header_ack_i,
  input  logic                rtrn_val_i,
  output logic [OUTST_W-1:0]  outstanding_o,
  output logic                full_o,
  output logic                err_o
`ifdef L15_REQ_BUF_STATS_EN
  ,
  output logic [STATS_W-1:0]  stall_full_cnt_o,
  output logic [STATS_W-1:0]  stall_credit_cnt_o
`endif
);

  localparam int unsigned CW = $clog2(Depth) + 1;
  localparam logic [OUTST_W-1:0] MaxOut = OUTST_W'(MaxOutstanding);

  state_e              state;
  logic                push;
  logic                pop;
  logic                inc;
  logic                dec;
  logic                has_next;
  logic [ReqWidth-1:0] head_dat;
  logic [ReqWidth-1:0] next_dat;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_cnt;

  assign core_ack_o = core_val_i & ~fifo_full;
  assign full_o     = fifo_full;
  assign push       = core_ack_o;
  assign pop        = l15_val_o & l15_header_ack_i;
  // Something remains to present after this cycle's pop.
  assign has_next   = (fifo_cnt > CW'(1)) | push;
  assign inc        = pop;
  assign dec        = rtrn_val_i & ((outstanding_o != '0) | inc);

  l15_req_fifo #(
    .ReqWidth (ReqWidth),
    .Depth    (Depth)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push),
    .push_dat (core_req_i),
    .pop      (pop),
    .head_dat (head_dat),
    .next_dat (next_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .cnt      (fifo_cnt)
  );

  // Presentation FSM: registered valid/payload held until the L1.5 acks the header.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      l15_val_o <= 1'b0;
      l15_req_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((~fifo_empty | push) && (outstanding_o < MaxOut)) begin
            state     <= PRESENT;
            l15_val_o <= 1'b1;
            // An empty FIFO being pushed this cycle forwards the core payload directly.
            l15_req_o <= fifo_empty ? core_req_i : head_dat;
          end
        end
        PRESENT: begin
          if (l15_header_ack_i) begin
            if (has_next && ((outstanding_o + 1'b1) < MaxOut)) begin
              l15_req_o <= (fifo_cnt > CW'(1)) ? next_dat : core_req_i;
            end else begin
              state     <= IDLE;
              l15_val_o <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          l15_val_o <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding credit counter: up on header ack, down on return, never below zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   outstanding_o <= outstanding_o + 1'b1;
        2'b01:   outstanding_o <= outstanding_o - 1'b1;
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

  // Sticky error on a header ack with nothing presented or a return with nothing outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= 1'b0;
    end else if ((l15_header_ack_i & ~l15_val_o) |
                 (rtrn_val_i & ~inc & (outstanding_o == '0))) begin
      err_o <= 1'b1;
    end
  end

`ifdef L15_REQ_BUF_STATS_EN
  // Saturating stall statistics: core blocked by a full FIFO, or queue blocked by credit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_full_cnt_o   <= '0;
      stall_credit_cnt_o <= '0;
    end else begin
      if (core_val_i & fifo_full) begin
        stall_full_cnt_o <= sat_inc(stall_full_cnt_o);
      end
      if (~fifo_empty && (state == IDLE) && (outstanding_o == MaxOut)) begin
        stall_credit_cnt_o <= sat_inc(stall_credit_cnt_o);
      end
    end
  end
`endif

endmodule

// File: tb/tb_l15_req_buffer.sv
// Self-checking bench for l15_req_buffer: directed table, corner sequences, randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_l15_req_buffer;

  localparam int DEPTH = 4;
  localparam int MAXO  = 7;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         core_val_i;
  logic [127:0] core_req_i;
  logic         core_ack_o;
  logic         l15_val_o;
  logic [127:0] l15_req_o;
  logic         l15_header_ack_i;
  logic         rtrn_val_i;
  logic [7:0]   outstanding_o;
  logic         full_o;
  logic         err_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  l15_req_buffer #(
    .ReqWidth       (128),
    .Depth          (DEPTH),
    .MaxOutstanding (MAXO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .core_val_i       (core_val_i),
    .core_req_i       (core_req_i),
    .core_ack_o       (core_ack_o),
    .l15_val_o        (l15_val_o),
    .l15_req_o        (l15_req_o),
    .l15_header_ack_i (l15_header_ack_i),
    .rtrn_val_i       (rtrn_val_i),
    .outstanding_o    (outstanding_o),
    .full_o           (full_o),
    .err_o            (err_o)
  );

  // Reference model: the queue holds every accepted, not-yet-acked request (head is the presented one).
  logic [127:0] m_q[$];
  bit           m_pres;
  logic [127:0] m_dat;
  int           m_outs;
  bit           m_err;

  task automatic model_reset();
    m_q.delete();
    m_pres = 0;
    m_dat  = '0;
    m_outs = 0;
    m_err  = 0;
  endtask

  task automatic model_step(input bit v, input logic [127:0] r, input bit h, input bit rt);
    bit acc;
    bit ack;
    int o;
    acc = h && m_pres;
    ack = v && (m_q.size() < DEPTH);
    o   = m_outs;
    if (h && !m_pres) m_err = 1;
    if (rt && o == 0 && !acc) m_err = 1;
    m_outs = o + (acc ? 1 : 0) - ((rt && (o > 0 || acc)) ? 1 : 0);
    if (acc) void'(m_q.pop_front());
    if (ack) m_q.push_back(r);
    if (m_pres && acc)  m_pres = (m_q.size() > 0) && (o + 1 < MAXO);
    else if (!m_pres)   m_pres = (m_q.size() > 0) && (o < MAXO);
    if (m_pres) m_dat = m_q[0];
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("core_ack", core_ack_o, core_val_i && (m_q.size() < DEPTH));
    chk("full", full_o, m_q.size() == DEPTH);
    chk("l15_val", l15_val_o, m_pres);
    if (m_pres) chk("l15_req", l15_req_o, m_dat);
    chk("outstanding", outstanding_o, m_outs);
    chk("err", err_o, m_err);
  endtask

  // One clock: drive at the falling edge, check just after, advance the model for the next rising edge.
  task automatic cycle(input bit v, input logic [127:0] r, input bit h, input bit rt);
    @(negedge clk_i);
    core_val_i       = v;
    core_req_i       = r;
    l15_header_ack_i = h;
    rtrn_val_i       = rt;
    #1;
    check_model();
    model_step(v, r, h, rt);
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_ack"}, core_ack_o, 1'b0);
    chk({nm, "_val"}, l15_val_o, 1'b0);
    chk({nm, "_req"}, l15_req_o, 128'h0);
    chk({nm, "_outs"}, outstanding_o, 8'd0);
    chk({nm, "_full"}, full_o, 1'b0);
    chk({nm, "_err"}, err_o, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    core_val_i = 0; core_req_i = '0; l15_header_ack_i = 0; rtrn_val_i = 0;
    rst_ni = 0;
    #1;
    check_reset_vals("reset");
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
  endtask

  typedef struct {
    bit           v;
    logic [127:0] r;
    bit           h;
    bit           rt;
    bit           e_ack;
    bit           e_val;
    logic [127:0] e_req;
    int           e_outs;
    bit           e_full;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst_ni = 0; core_val_i = 0; core_req_i = '0; l15_header_ack_i = 0; rtrn_val_i = 0;
    model_reset();
    #3;
    check_reset_vals("por");
    repeat (2) @(negedge clk_i);
    rst_ni = 1;

    // Single request held until ack, then fill the FIFO with the L1.5 stalled.
    tbl[0]  = '{1, 128'hA5, 0, 0, 1, 0, 128'h0,  0, 0};
    tbl[1]  = '{0, 128'h0,  0, 0, 0, 1, 128'hA5, 0, 0};
    tbl[2]  = '{0, 128'h0,  0, 0, 0, 1, 128'hA5, 0, 0};
    tbl[3]  = '{0, 128'h0,  1, 0, 0, 1, 128'hA5, 0, 0};
    tbl[4]  = '{0, 128'h0,  0, 0, 0, 0, 128'h0,  1, 0};
    tbl[5]  = '{1, 128'hB0, 0, 0, 1, 0, 128'h0,  1, 0};
    tbl[6]  = '{1, 128'hB1, 0, 0, 1, 1, 128'hB0, 1, 0};
    tbl[7]  = '{1, 128'hB2, 0, 0, 1, 1, 128'hB0, 1, 0};
    tbl[8]  = '{1, 128'hB3, 0, 0, 1, 1, 128'hB0, 1, 0};
    tbl[9]  = '{1, 128'hB4, 0, 0, 0, 1, 128'hB0, 1, 1};
    tbl[10] = '{1, 128'hB4, 1, 0, 0, 1, 128'hB0, 1, 1};
    tbl[11] = '{1, 128'hB4, 0, 0, 1, 1, 128'hB1, 2, 0};
    tbl[12] = '{0, 128'h0,  0, 0, 0, 1, 128'hB1, 2, 1};
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].v, tbl[i].r, tbl[i].h, tbl[i].rt);
      chk("tbl_ack", core_ack_o, tbl[i].e_ack);
      chk("tbl_val", l15_val_o, tbl[i].e_val);
      if (tbl[i].e_val) chk("tbl_req", l15_req_o, tbl[i].e_req);
      chk("tbl_outs", outstanding_o, tbl[i].e_outs);
      chk("tbl_full", full_o, tbl[i].e_full);
    end

    // Back-to-back issue with header ack held high.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 128'h100 + i, 1, 0);
      if (i > 0) begin
        chk("b2b_val", l15_val_o, 1'b1);
        chk("b2b_req", l15_req_o, 128'h100 + i - 1);
      end
    end
    cycle(0, '0, 1, 0);
    chk("b2b_last_req", l15_req_o, 128'h103);
    cycle(0, '0, 0, 0);
    chk("b2b_outs", outstanding_o, 8'd4);
    chk("b2b_idle", l15_val_o, 1'b0);

    // Credit limit: reach MaxOutstanding, stall, then one return resumes issue.
    for (int k = 0; k < 6; k++) cycle(1, 128'h200 + k, 1, 0);
    cycle(0, '0, 0, 0);
    chk("credit_outs", outstanding_o, 8'd7);
    chk("credit_stall", l15_val_o, 1'b0);
    cycle(0, '0, 0, 0);
    chk("credit_stall2", l15_val_o, 1'b0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 0);
    chk("credit_drop", outstanding_o, 8'd6);
    chk("credit_still0", l15_val_o, 1'b0);
    cycle(0, '0, 0, 0);
    chk("credit_resume", l15_val_o, 1'b1);
    chk("credit_req", l15_req_o, 128'h203);

    // Simultaneous ack and return, then a spurious return sets the sticky error.
    do_reset();
    cycle(1, 128'hD0, 0, 0);
    cycle(1, 128'hD1, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 1, 1);
    chk("sim_req", l15_req_o, 128'hD1);
    cycle(0, '0, 0, 0);
    chk("sim_outs", outstanding_o, 8'd1);
    chk("sim_err", err_o, 1'b0);
    cycle(0, '0, 0, 1);
    cycle(0, '0, 0, 1);
    chk("spur_pre_err", err_o, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 0, 0);
      chk("spur_err", err_o, 1'b1);
      chk("spur_outs", outstanding_o, 8'd0);
    end

    // Reset while presenting: everything clears at once and nothing is re-presented.
    do_reset();
    cycle(1, 128'hE0, 0, 0);
    cycle(1, 128'hE1, 0, 0);
    cycle(0, '0, 1, 0);
    cycle(0, '0, 0, 0);
    chk("mid_pre_val", l15_val_o, 1'b1);
    chk("mid_pre_req", l15_req_o, 128'hE1);
    chk("mid_pre_outs", outstanding_o, 8'd1);
    #1 rst_ni = 0;
    #1;
    chk("mid_rst_val", l15_val_o, 1'b0);
    chk("mid_rst_outs", outstanding_o, 8'd0);
    chk("mid_rst_full", full_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(0, '0, 0, 0);
      chk("post_rst_idle", l15_val_o, 1'b0);
    end
    cycle(1, 128'hE2, 0, 0);
    cycle(0, '0, 0, 0);
    chk("post_rst_val", l15_val_o, 1'b1);
    chk("post_rst_req", l15_req_o, 128'hE2);

    // Randomized traffic against the model, with varying return rates to exercise the credit limit.
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      for (int n = 0; n < 1000; n++) begin
        bit           v;
        bit           h;
        bit           rt;
        logic [127:0] r;
        v  = ($urandom_range(0, 3) != 0);
        r  = {$urandom, $urandom, $urandom, $urandom};
        h  = m_pres ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 199) == 0);
        rt = (m_outs > 0) ? ($urandom_range(0, 2 + 4 * ph) == 0) : ($urandom_range(0, 199) == 0);
        cycle(v, r, h, rt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
